bp_cfg_sequencer: RTL and testbench

- Programmable configuration sequencer that replays a table of config-bus writes to one or more cores after reset or on command.
- Successor to fixed compile-time config selection: the table depth and core count are parameters, the table is loaded at runtime, and a per-entry broadcast mode expands one entry into one write per core.
- Sits between the host/debug loader and the cfg network feeding each core's config registers.

---
 rtl/bp_cfg_sequencer_pkg.sv | 32 +++
 rtl/bp_cfg_seq_table.sv | 56 +++++
 rtl/bp_cfg_sequencer.sv | 173 +++++++++++++++++
 tb/tb_bp_cfg_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bp_cfg_sequencer_pkg
// Shared types for the configuration sequencer.
//   BP_CFG_ENTRY_S_M(core_w, addr_w, data_w) : declares the packed table entry
//       type bp_cfg_entry_s = {bcast, core, addr, data} at the widths of the
//       module that expands it. It is a macro because the widths are module
//       parameters, which a package typedef cannot follow.
//   bp_cfg_seq_state_e : sequencer FSM states.
//   safe_clog2         : clog2 that never returns 0, so index ports stay legal
//                        for single-entry tables.
// -----------------------------------------------------------------------------
`define BP_CFG_ENTRY_S_M(core_w, addr_w, data_w) \
   typedef struct packed {                       \
      logic                  bcast;              \
      logic [(core_w)-1:0]   core;               \
      logic [(addr_w)-1:0]   addr;               \
      logic [(data_w)-1:0]   data;               \
   } bp_cfg_entry_s

package bp_cfg_sequencer_pkg;

   typedef enum logic [1:0] {
      e_idle = 2'd0,
      e_send = 2'd1,
      e_done = 2'd2
   } bp_cfg_seq_state_e;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bp_cfg_seq_table.sv
// -----------------------------------------------------------------------------
// bp_cfg_seq_table
// els_p x width_p register file, one write port, one registered read port.
//   clk_i    : clock
//   w_v_i    : write enable (caller guarantees w_idx_i < els_p)
//   w_idx_i  : write index
//   w_data_i : write data
//   r_v_i    : read enable; when low the read register holds its value
//   r_idx_i  : read index
//   r_data_o : registered read data, valid the cycle after r_v_i
// Contents and the read register are intentionally not reset.
// -----------------------------------------------------------------------------
module bp_cfg_seq_table #(
   parameter int els_p    = 16,
   parameter int width_p  = 57,
   parameter int lg_els_p = 4
) (
   input  logic                clk_i,
   input  logic                w_v_i,
   input  logic [lg_els_p-1:0] w_idx_i,
   input  logic [width_p-1:0]  w_data_i,
   input  logic                r_v_i,
   input  logic [lg_els_p-1:0] r_idx_i,
   output logic [width_p-1:0]  r_data_o
);

   logic [width_p-1:0] mem_q [els_p];
   logic [width_p-1:0] r_data_q;
   logic [width_p-1:0] r_data_d;

   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_q[w_idx_i] <= w_data_i;
      end
   end

   // Same-cycle write to the entry being read is forwarded, so a table load
   // coincident with a start is seen by the prefetch of entry 0.
   always_comb begin
      r_data_d = r_data_q;
      if (r_v_i) begin
         if (w_v_i && (w_idx_i == r_idx_i)) begin
            r_data_d = w_data_i;
         end else begin
            r_data_d = mem_q[r_idx_i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      r_data_q <= r_data_d;
   end

   assign r_data_o = r_data_q;

endmodule

// File: rtl/bp_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// bp_cfg_sequencer
// Replays a runtime-loaded table of config-bus writes to the cores. A
// broadcast entry is expanded into one write per core (core ids 0..num_core_p-1).
//   clk_i, reset_n_i    : clock, asynchronous active-low reset
//   tbl_w_v_i/idx/entry : table load port, {bcast, core, addr, data}; idle only
//   len_i, start_i      : number of entries to replay, replay trigger
//   cfg_*_o, cfg_ready_i: valid/ready config write channel
//   busy_o, done_o      : replay in progress, one-cycle completion pulse
//   err_o               : sticky protocol error (cleared only by reset)
// reset_n_i is expected to be released synchronously to clk_i by the upstream
// reset generator; assertion is fully asynchronous so cfg_v_o drops at once.
// -----------------------------------------------------------------------------
module bp_cfg_sequencer
   import bp_cfg_sequencer_pkg::*;
#(
   parameter  int num_core_p       = 4,
   parameter  int cfg_core_width_p = 8,
   parameter  int cfg_addr_width_p = 16,
   parameter  int cfg_data_width_p = 32,
   parameter  int els_p            = 16,
   localparam int lg_els_lp        = safe_clog2(els_p),
   localparam int entry_width_lp   = 1 + cfg_core_width_p + cfg_addr_width_p + cfg_data_width_p
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        tbl_w_v_i,
   input  logic [lg_els_lp-1:0]        tbl_w_idx_i,
   input  logic [entry_width_lp-1:0]   tbl_w_entry_i,
   input  logic [lg_els_lp:0]          len_i,
   input  logic                        start_i,
   output logic                        cfg_v_o,
   output logic [cfg_core_width_p-1:0] cfg_core_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_ready_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);

   `BP_CFG_ENTRY_S_M(cfg_core_width_p, cfg_addr_width_p, cfg_data_width_p);

   localparam logic [lg_els_lp:0]          els_lim_lp   = (lg_els_lp+1)'(els_p);
   localparam logic [cfg_core_width_p-1:0] last_core_lp = cfg_core_width_p'(num_core_p - 1);

   bp_cfg_seq_state_e           state_q, state_d;
   logic [lg_els_lp-1:0]        entry_idx_q, entry_idx_d;
   logic [cfg_core_width_p-1:0] core_idx_q, core_idx_d;
   logic [lg_els_lp:0]          len_q, len_d;
   logic                        err_q, err_d;

   logic                        busy;
   logic                        tbl_idx_oob;
   logic                        tbl_w_ok;
   logic                        last_entry;
   logic                        rd_v;
   logic [lg_els_lp-1:0]        rd_idx;
   logic [entry_width_lp-1:0]   rd_data;
   bp_cfg_entry_s               rd_entry;

   assign busy        = (state_q != e_idle);
   assign tbl_idx_oob = (int'(tbl_w_idx_i) >= els_p);
   assign tbl_w_ok    = tbl_w_v_i & ~busy & ~tbl_idx_oob;
   assign last_entry  = (({1'b0, entry_idx_q} + (lg_els_lp+1)'(1)) == len_q);

   bp_cfg_seq_table #(
      .els_p    (els_p),
      .width_p  (entry_width_lp),
      .lg_els_p (lg_els_lp)
   ) u_table (
      .clk_i    (clk_i),
      .w_v_i    (tbl_w_ok),
      .w_idx_i  (tbl_w_idx_i),
      .w_data_i (tbl_w_entry_i),
      .r_v_i    (rd_v),
      .r_idx_i  (rd_idx),
      .r_data_o (rd_data)
   );

   assign rd_entry = rd_data;

   always_comb begin
      state_d     = state_q;
      entry_idx_d = entry_idx_q;
      core_idx_d  = core_idx_q;
      len_d       = len_q;
      err_d       = err_q;
      rd_v        = 1'b0;
      rd_idx      = entry_idx_q + lg_els_lp'(1);
      cfg_v_o     = 1'b0;
      done_o      = 1'b0;

      if (tbl_w_v_i && (busy || tbl_idx_oob)) begin
         err_d = 1'b1;
      end

      case (state_q)
         e_idle: begin
            if (start_i) begin
               if (len_i > els_lim_lp) begin
                  len_d = els_lim_lp;
                  err_d = 1'b1;
               end else begin
                  len_d = len_i;
               end
               entry_idx_d = '0;
               core_idx_d  = '0;
               // Prefetch entry 0 so the first write appears the next cycle.
               rd_v        = 1'b1;
               rd_idx      = '0;
               state_d     = (len_i == '0) ? e_done : e_send;
            end
         end

         e_send: begin
            cfg_v_o = 1'b1;
            if (start_i) begin
               err_d = 1'b1;
            end
            if (cfg_ready_i) begin
               if (rd_entry.bcast && (core_idx_q != last_core_lp)) begin
                  core_idx_d = core_idx_q + cfg_core_width_p'(1);
               end else begin
                  core_idx_d  = '0;
                  entry_idx_d = entry_idx_q + lg_els_lp'(1);
                  if (last_entry) begin
                     state_d = e_done;
                  end else begin
                     // Fetch the next entry now so it is on the bus next cycle.
                     rd_v = 1'b1;
                  end
               end
            end
         end

         e_done: begin
            done_o  = 1'b1;
            if (start_i) begin
               err_d = 1'b1;
            end
            state_d = e_idle;
         end

         default: begin
            state_d = e_idle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= e_idle;
         entry_idx_q <= '0;
         core_idx_q  <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_idx_q <= entry_idx_d;
         core_idx_q  <= core_idx_d;
         len_q       <= len_d;
         err_q       <= err_d;
      end
   end

   assign cfg_core_o = rd_entry.bcast ? core_idx_q : rd_entry.core;
   assign cfg_addr_o = rd_entry.addr;
   assign cfg_data_o = rd_entry.data;
   assign busy_o     = busy;
   assign err_o      = err_q;

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
`timescale 1ns/1ps
module tb_bp_cfg_sequencer;

   localparam int NC  = 4;
   localparam int CW  = 8;
   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int ELS = 16;
   localparam int LG  = 4;
   localparam int EW  = 1 + CW + AW + DW;

   logic          clk           = 1'b0;
   logic          reset_n_i     = 1'b0;
   logic          tbl_w_v_i     = 1'b0;
   logic [LG-1:0] tbl_w_idx_i   = '0;
   logic [EW-1:0] tbl_w_entry_i = '0;
   logic [LG:0]   len_i         = '0;
   logic          start_i       = 1'b0;
   logic          cfg_ready_i   = 1'b1;
   logic          cfg_v_o;
   logic [CW-1:0] cfg_core_o;
   logic [AW-1:0] cfg_addr_o;
   logic [DW-1:0] cfg_data_o;
   logic          busy_o;
   logic          done_o;
   logic          err_o;

   always #5 clk = ~clk;

   bp_cfg_sequencer #(
      .num_core_p       (NC),
      .cfg_core_width_p (CW),
      .cfg_addr_width_p (AW),
      .cfg_data_width_p (DW),
      .els_p            (ELS)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n_i),
      .tbl_w_v_i     (tbl_w_v_i),
      .tbl_w_idx_i   (tbl_w_idx_i),
      .tbl_w_entry_i (tbl_w_entry_i),
      .len_i         (len_i),
      .start_i       (start_i),
      .cfg_v_o       (cfg_v_o),
      .cfg_core_o    (cfg_core_o),
      .cfg_addr_o    (cfg_addr_o),
      .cfg_data_o    (cfg_data_o),
      .cfg_ready_i   (cfg_ready_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic [CW-1:0] core;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   typedef struct {
      logic          bcast;
      logic [CW-1:0] core;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct {
      int   idx;
      ent_t e;
      int   exp_writes;
   } vec_t;

   wr_t  exp_q[$];
   ent_t model[ELS];
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   rand_ready   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ready driver: held high, or 50% random backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cfg_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard monitor: pops one expected write per transfer and checks that
   // a stalled write is held unchanged until it transfers.
   logic stall_q = 1'b0;
   wr_t  held_q;
   always @(negedge clk) begin
      wr_t cur;
      wr_t e;
      cur = {cfg_core_o, cfg_addr_o, cfg_data_o};
      if (reset_n_i && stall_q) begin
         chk("hold_valid", cfg_v_o, 1);
         chk("hold_payload", cur, held_q);
      end
      if (cfg_v_o && cfg_ready_i) begin
         $display("[TB] write core=0x%0h addr=0x%0h data=0x%0h", cfg_core_o, cfg_addr_o, cfg_data_o);
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_write: got 0x%0h, expected no write", cur);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
               tests_failed++;
               $display("FAIL write: got 0x%0h, expected 0x%0h", cur, e);
            end
         end
      end
      stall_q = reset_n_i && cfg_v_o && !cfg_ready_i;
      held_q  = cur;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input ent_t e);
      tbl_w_v_i     = 1'b1;
      tbl_w_idx_i   = LG'(idx);
      tbl_w_entry_i = {e.bcast, e.core, e.addr, e.data};
      tick();
      tbl_w_v_i     = 1'b0;
      model[idx]    = e;
   endtask

   function automatic ent_t mk(input logic b, input logic [CW-1:0] c,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
      ent_t e;
      e.bcast = b; e.core = c; e.addr = a; e.data = d;
      return e;
   endfunction

   // Reference expansion of a replay of the first len entries.
   function automatic void push_exp(input int len);
      int n;
      n = (len > ELS) ? ELS : len;
      for (int i = 0; i < n; i++) begin
         if (model[i].bcast) begin
            for (int c = 0; c < NC; c++) exp_q.push_back({CW'(c), model[i].addr, model[i].data});
         end else begin
            exp_q.push_back({model[i].core, model[i].addr, model[i].data});
         end
      end
   endfunction

   // Pulse start and observe until done; n counts cycles after the start edge.
   task automatic run(input string name, input int len, output int first_v,
                      output int busy_n, output int done_n, output int nwr);
      bit fin;
      start_i = 1'b1;
      len_i   = (LG+1)'(len);
      tick();
      start_i   = 1'b0;
      tbl_w_v_i = 1'b0;
      first_v = -1; busy_n = 0; done_n = 0; nwr = 0; fin = 0;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk);
         if (cfg_v_o && first_v < 0) first_v = n;
         if (cfg_v_o && cfg_ready_i) nwr++;
         if (busy_o) busy_n++;
         if (done_o) done_n++;
         if (done_n > 0 && !busy_o) begin
            fin = 1;
            break;
         end
      end
      chk({name, "_complete"}, fin, 1);
      tick();
   endtask

   initial begin
      vec_t vecs[4];
      int   fv, bn, dn, nw, expw;
      bit   inj;

      vecs[0] = '{idx: 0, e: mk(1'b0, 8'd0, 16'h0010, 32'h1), exp_writes: 1};
      vecs[1] = '{idx: 1, e: mk(1'b0, 8'd1, 16'h0020, 32'h2), exp_writes: 1};
      vecs[2] = '{idx: 2, e: mk(1'b0, 8'd3, 16'h0030, 32'h3), exp_writes: 1};
      vecs[3] = '{idx: 0, e: mk(1'b1, 8'hAA, 16'h0100, 32'hDEADBEEF), exp_writes: NC};

      // Reset state
      reset_n_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_v", cfg_v_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      reset_n_i = 1'b1;
      tick();

      // Three point-to-point entries, ready held high
      expw = 0;
      for (int i = 0; i < 3; i++) begin
         load(vecs[i].idx, vecs[i].e);
         expw += vecs[i].exp_writes;
      end
      push_exp(3);
      run("basic", 3, fv, bn, dn, nw);
      chk("basic_latency", fv, 1);
      chk("basic_busy_cycles", bn, 4);
      chk("basic_done", dn, 1);
      chk("basic_writes", nw, expw);
      chk("basic_drained", exp_q.size(), 0);

      // Single broadcast entry expands to one write per core
      load(vecs[3].idx, vecs[3].e);
      push_exp(1);
      run("bcast", 1, fv, bn, dn, nw);
      chk("bcast_writes", nw, vecs[3].exp_writes);
      chk("bcast_busy_cycles", bn, NC + 1);
      chk("bcast_done", dn, 1);
      chk("bcast_drained", exp_q.size(), 0);
      chk("bcast_err", err_o, 0);

      // 16 entries under random backpressure
      for (int i = 0; i < ELS; i++) begin
         load(i, mk(1'b0, CW'($urandom_range(0, NC - 1)), AW'($urandom), DW'($urandom)));
      end
      rand_ready = 1'b1;
      push_exp(ELS);
      run("bp", ELS, fv, bn, dn, nw);
      rand_ready = 1'b0;
      tick();
      chk("bp_writes", nw, ELS);
      chk("bp_done", dn, 1);
      chk("bp_drained", exp_q.size(), 0);

      // len=0: straight to done, no writes, no error
      run("len0", 0, fv, bn, dn, nw);
      chk("len0_no_valid", fv < 0, 1);
      chk("len0_busy_cycles", bn, 1);
      chk("len0_done", dn, 1);
      chk("len0_err", err_o, 0);

      // len=20 is clamped to the table depth and flagged
      push_exp(20);
      run("clamp", 20, fv, bn, dn, nw);
      chk("clamp_writes", nw, ELS);
      chk("clamp_err", err_o, 1);
      chk("clamp_drained", exp_q.size(), 0);

      // Mid-replay start and table write are ignored, then reset aborts at write 5
      reset_n_i = 1'b0;
      tick();
      tick();
      reset_n_i = 1'b1;
      tick();
      chk("reset_clears_err", err_o, 0);
      push_exp(5);
      start_i = 1'b1;
      len_i   = (LG+1)'(ELS);
      tick();
      start_i = 1'b0;
      nw = 0; dn = 0; inj = 0;
      for (int n = 0; n < 500 && nw < 5; n++) begin
         @(negedge clk);
         if (cfg_v_o && cfg_ready_i) nw++;
         if (done_o) dn++;
         @(posedge clk);
         #1;
         start_i   = 1'b0;
         tbl_w_v_i = 1'b0;
         if (nw == 2 && !inj) begin
            inj           = 1;
            start_i       = 1'b1;
            len_i         = (LG+1)'(3);
            tbl_w_v_i     = 1'b1;
            tbl_w_idx_i   = LG'(10);
            tbl_w_entry_i = {1'b1, 8'h55, 16'hFFFF, 32'hBADBAD00};
         end
      end
      start_i   = 1'b0;
      tbl_w_v_i = 1'b0;
      chk("abort_reached_write5", nw, 5);
      chk("mid_err", err_o, 1);
      chk("mid_valid", cfg_v_o, 1);
      chk("mid_payload", {cfg_core_o, cfg_addr_o, cfg_data_o},
          {model[5].core, model[5].addr, model[5].data});
      reset_n_i = 1'b0;
      #1;
      chk("abort_valid_async", cfg_v_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_err", err_o, 0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (done_o) dn++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_drained", exp_q.size(), 0);

      // Release reset and start at once: retained table replays in full
      tick();
      reset_n_i = 1'b1;
      push_exp(ELS);
      run("retain", ELS, fv, bn, dn, nw);
      chk("retain_writes", nw, ELS);
      chk("retain_done", dn, 1);
      chk("retain_drained", exp_q.size(), 0);

      // Table write coincident with start commits first
      tbl_w_v_i     = 1'b1;
      tbl_w_idx_i   = '0;
      tbl_w_entry_i = {1'b0, 8'd2, 16'hBEEF, 32'h12345678};
      model[0]      = mk(1'b0, 8'd2, 16'hBEEF, 32'h12345678);
      push_exp(1);
      run("wr_start", 1, fv, bn, dn, nw);
      chk("wr_start_writes", nw, 1);
      chk("wr_start_latency", fv, 1);
      chk("wr_start_err", err_o, 0);
      chk("wr_start_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
